// File: rtl/guess_pkg.sv
// guess_pkg -- shared types and helpers for the guessing-game round timer.
//   state_t    : round timer FSM states (2-bit)
//   bcd_t      : one BCD digit (4-bit)
//   bcd_pair_t : tens/ones digit pair
//   bcd_dec    : one-second BCD decrement, saturating at 00
package guess_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t ones;
  } bcd_pair_t;

  // Returns the pair one second lower. The ones digit borrows from the tens
  // digit when it wraps 0 -> 9. 00 stays at 00, so the count can never
  // underflow even if a stray tick arrives.
  function automatic bcd_pair_t bcd_dec(input bcd_pair_t cur);
    bcd_pair_t nxt;
    nxt = cur;
    if (cur.ones != 4'd0) begin
      nxt.ones = cur.ones - 4'd1;
    end else if (cur.tens != 4'd0) begin
      nxt.ones = 4'd9;
      nxt.tens = cur.tens - 4'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/guess_timer_sync_edge.sv
// sync_edge -- brings an asynchronous level into the iclk domain and turns
// each rising edge into a single-cycle pulse. Reusable for button inputs.
//   iclk   : system clock
//   reset  : asynchronous active-high reset, clears every flop
//   din    : asynchronous input level
//   tick   : registered one-cycle pulse, STAGES+1 cycles after a din rise
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic iclk,
  input  logic reset,
  input  logic din,
  output logic tick
);

  if (STAGES < 2 || STAGES > 3) begin : g_bad_stages
    $fatal(1, "sync_edge: STAGES must be 2..3");
  end

  logic [STAGES-1:0] sync_reg;
  logic [STAGES-1:0] sync_next;
  logic              prev_reg;
  logic              tick_reg;

  // Each stage samples the one before it; stage 0 samples the raw input.
  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_chain
      if (gi == 0) begin : g_first
        assign sync_next[gi] = din;
      end else begin : g_rest
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge iclk or posedge reset) begin
    if (reset) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
      tick_reg <= 1'b0;
    end else begin
      sync_reg <= sync_next;
      prev_reg <= sync_reg[STAGES-1];
      tick_reg <= sync_reg[STAGES-1] & ~prev_reg;
    end
  end

  assign tick = tick_reg;

endmodule

// File: rtl/guess_timer.sv
// guess_timer -- BCD seconds countdown for one guessing round.
//   iclk     : 50 MHz system clock
//   reset    : asynchronous active-high reset
//   slowclk  : ~1 Hz divider output, sampled as data
//   start    : one-cycle pulse, (re)loads SECONDS and enters RUN
//   hold     : level, pauses the countdown while high
//   tens     : BCD tens digit of seconds remaining
//   ones     : BCD ones digit of seconds remaining
//   running  : high in RUN only
//   done     : high in DONE
//   expired  : one-cycle pulse on entry to DONE
//   tick     : synchronized one-cycle pulse per slowclk rising edge
module guess_timer
  import guess_pkg::*;
#(
  parameter int SECONDS     = 30,
  parameter int SYNC_STAGES = 2
) (
  input  logic       iclk,
  input  logic       reset,
  input  logic       slowclk,
  input  logic       start,
  input  logic       hold,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       done,
  output logic       expired,
  output logic       tick
);

  if (SECONDS < 1 || SECONDS > 99) begin : g_bad_seconds
    $fatal(1, "guess_timer: SECONDS must be 1..99");
  end

  localparam bcd_t LOAD_TENS = bcd_t'(SECONDS / 10);
  localparam bcd_t LOAD_ONES = bcd_t'(SECONDS % 10);
  localparam bcd_pair_t LOAD_PAIR = '{tens: LOAD_TENS, ones: LOAD_ONES};

  logic tick_w;

  sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .iclk  (iclk),
    .reset (reset),
    .din   (slowclk),
    .tick  (tick_w)
  );

  state_t    state_reg,   state_next;
  bcd_pair_t digits_reg,  digits_next;
  logic      running_reg, done_reg;
  logic      expired_reg, expired_next;

  always_comb begin
    state_next   = state_reg;
    digits_next  = digits_reg;
    expired_next = 1'b0;
    // start outranks both hold and tick in every state.
    if (start) begin
      state_next  = RUN;
      digits_next = LOAD_PAIR;
    end else begin
      case (state_reg)
        IDLE: ;
        RUN: begin
          // hold wins a same-cycle collision; that tick is simply lost.
          if (hold) begin
            state_next = HOLD;
          end else if (tick_w) begin
            digits_next = bcd_dec(digits_reg);
            if (digits_reg.tens == 4'd0 && digits_reg.ones == 4'd1) begin
              state_next   = DONE;
              expired_next = 1'b1;
            end
          end
        end
        HOLD: begin
          if (!hold) begin
            state_next = RUN;
          end
        end
        DONE: ;
        default: state_next = IDLE;
      endcase
    end
  end

  // Flag outputs are decoded from the next state so they change on the same
  // edge as the state register.
  always_ff @(posedge iclk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      digits_reg  <= '0;
      running_reg <= 1'b0;
      done_reg    <= 1'b0;
      expired_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      digits_reg  <= digits_next;
      running_reg <= (state_next == RUN);
      done_reg    <= (state_next == DONE);
      expired_reg <= expired_next;
    end
  end

  assign tens    = digits_reg.tens;
  assign ones    = digits_reg.ones;
  assign running = running_reg;
  assign done    = done_reg;
  assign expired = expired_reg;
  assign tick    = tick_w;

endmodule

// File: doc/guess_timer.md
Name: guess_timer

Overview:
- Countdown round timer for the number-guessing game. It sits directly downstream of the clock divider.
- Takes the divider's slow square-wave output (nominal 1 Hz) as a data input, synchronizes it into the 50 MHz system clock domain and edge-detects it into one-cycle tick pulses.
- Runs a BCD seconds countdown per guessing round and emits the remaining time for the seven-segment decoders plus an expiry indication for the game FSM.

Parameters:
- SECONDS, 30: round length loaded on start; legal range 1..99.
- SYNC_STAGES, 2: flip-flop depth of the slowclk synchronizer; legal range 2..3.

Ports:
- iclk  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-high reset.
- slowclk  input  1  divided clock from the clock divider; treated as asynchronous data, never used as a clock.
- start  input  1  one-cycle pulse; loads SECONDS and begins counting.
- hold  input  1  level; while high in RUN, ticks are ignored.
- tens  output  4  BCD tens digit of seconds remaining.
- ones  output  4  BCD ones digit of seconds remaining.
- running  output  1  high in RUN state only.
- done  output  1  level, high in DONE state.
- expired  output  1  one-cycle pulse on the transition into DONE.
- tick  output  1  one-cycle pulse per slowclk rising edge, after synchronization; exported for debug and LED blink.

Behaviour:
- Reset (asynchronous assert, synchronous to iclk on release):
  - state=IDLE; tens=0, ones=0, running=0, done=0, expired=0, tick=0.
  - All synchronizer and edge-detect flops clear to 0.
- Synchronizer and edge detect:
  - slowclk passes through SYNC_STAGES flops, then one more "previous" flop.
  - tick = sync_out & ~prev, registered.
  - Latency from slowclk rise to tick is SYNC_STAGES+1 iclk cycles.
  - If slowclk is high at reset release, one tick fires after that latency. This is acceptable: it is ignored outside RUN.
- States are IDLE, RUN, HOLD and DONE.
- IDLE:
  - Digits hold their value: 0 after reset, or the last value after an abort (there is no abort input, so effectively 0).
  - start -> RUN; digits load SECONDS split into tens and ones.
- RUN:
  - On tick, decrement the BCD count, with the borrow rule below.
  - A tick that takes the count from 01 to 00 -> DONE and asserts expired for exactly 1 cycle. The digits show 00 in that same cycle.
  - hold=1 (sampled without a tick) -> HOLD.
  - If hold=1 and tick occur in the same cycle, hold wins and the tick is dropped.
- HOLD:
  - Digits are frozen and ticks are ignored.
  - hold=0 -> RUN. The count resumes on the next tick; the partial second is not compensated.
- DONE:
  - Digits stay at 00 and done=1.
  - start -> RUN with a reload.
- BCD decrement (width and borrow rules):
  - ones!=0: ones-1.
  - ones==0: ones=9, tens-1.
  - Digits never exceed 9 and never underflow below 00.
- start in any state, including RUN and HOLD:
  - Reloads SECONDS and goes to RUN; this has priority over tick and hold in that cycle.
  - If hold is still high in the next cycle, the next-cycle rule applies and the state goes to HOLD.
- Digit load: tens = SECONDS/10 and ones = SECONDS%10, computed at elaboration as constants.
- Output registers and latency:
  - running, done and expired are registered and update in the same cycle as the state register.
  - Digits update 1 cycle after the tick pulse is visible.
- An illegal state encoding recovers to IDLE.
- Elaboration check: SECONDS outside 1..99 triggers a fatal assertion.

Decomposition:
- Package guess_pkg holds:
  - the state enum (IDLE, RUN, HOLD, DONE) as a 2-bit typedef;
  - the BCD digit typedef (4-bit logic);
  - the function bcd_dec, which returns the next tens/ones pair.
- Sub-module sync_edge contains the synchronizer chain plus rising-edge detect and produces tick. It is reusable for button inputs elsewhere in the game.

Test Plan:
- Reset mid-run with SECONDS=3:
  - Stimulus: start, one tick, then assert reset asynchronously between iclk edges.
  - Required: all outputs 0 immediately, state IDLE; later ticks do not change the digits.
- Full countdown with SECONDS=3 and slowclk toggling every 4 iclk cycles:
  - Stimulus: start.
  - Required: digits 03 -> 02 -> 01 -> 00, each change 1 cycle after tick.
  - expired high for exactly 1 cycle at 00, then done=1 and running=0.
- Borrow and wrap with SECONDS=12:
  - Stimulus: start, then three ticks.
  - Required: 12 -> 11 -> 10 -> 09; tens goes 1 -> 0 exactly when ones wraps 0 -> 9.
- Hold collision with SECONDS=5:
  - Stimulus: start, one tick (04), then hold=1 in the same cycle as a tick, keep hold high for two more ticks, then hold=0 and one tick.
  - Required: digits stay 04 while holding, then go to 03; running=0 during HOLD.
- Restart priority:
  - Stimulus: in RUN at 02, assert start in the same cycle as a tick; separately, assert start in DONE.
  - Required: both cases reload SECONDS (03), go to RUN and produce no expired pulse.
- Synchronizer latency with SYNC_STAGES=2:
  - Stimulus: slowclk rises asynchronously.
  - Required: tick asserts exactly 3 iclk cycles later, lasts 1 cycle, and does not fire on slowclk falling edges.
